// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-style computer: control-word bit positions,
// opcode values and a small bus-driver helper used by datapath and sequencer.
package sap_pkg;

  localparam int HLT_B = 15;
  localparam int MI_B  = 14;
  localparam int RI_B  = 13;
  localparam int RO_B  = 12;
  localparam int IO_B  = 11;
  localparam int II_B  = 10;
  localparam int AI_B  = 9;
  localparam int AO_B  = 8;
  localparam int EO_B  = 7;
  localparam int SU_B  = 6;
  localparam int BI_B  = 5;
  localparam int OI_B  = 4;
  localparam int CE_B  = 3;
  localparam int CO_B  = 2;
  localparam int J_B   = 1;
  localparam int FI_B  = 0;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_LDA = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_STA = 4'd4,
    OP_LDI = 4'd5,
    OP_JMP = 4'd6,
    OP_JC  = 4'd7,
    OP_JZ  = 4'd8,
    OP_OUT = 4'd14,
    OP_HLT = 4'd15
  } opcode_e;

  // True when two or more of the five bus-driver enables are set.
  function automatic logic multi_driver(input logic [4:0] drv);
    return ((drv & (drv - 5'd1)) != 5'd0);
  endfunction

endpackage

// File: rtl/sap_alu.sv
// Combinational 9-bit add/subtract unit; subtract is A + ~B + 1 so the carry
// out reads as "no borrow".
module sap_alu #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              su,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_b_op;

  always_comb begin
    w_b_op = su ? ~b : b;
    w_sum  = {1'b0, a} + {1'b0, w_b_op} + {{DATA_W{1'b0}}, su};
  end

  assign result = w_sum[DATA_W-1:0];
  assign carry  = w_sum[DATA_W];
  assign zero   = (w_sum[DATA_W-1:0] == {DATA_W{1'b0}});

endmodule

// File: rtl/sap_datapath.sv
// SAP execution datapath: decodes one control word per cycle onto the shared
// bus, registers, RAM, ALU, program counter and flags.
module sap_datapath
  import sap_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       ctrl_word,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [3:0]        instruction,
  output logic              carry_flag,
  output logic              zero_flag,
  output logic [DATA_W-1:0] out_data,
  output logic              halted,
  output logic              bus_conflict,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] bus
);

  logic [DATA_W-1:0] r_a, r_b, r_ir, r_out;
  logic [ADDR_W-1:0] r_mar, r_pc;
  logic              r_carry, r_zero, r_halted, r_conflict;
  logic [DATA_W-1:0] r_ram [2**ADDR_W];

  logic [15:0]       w_cw;
  logic [DATA_W-1:0] w_bus, w_alu;
  logic [4:0]        w_drv;
  logic              w_alu_c, w_alu_z;

  // A halted machine sees an all-zero control word.
  assign w_cw  = r_halted ? 16'h0000 : ctrl_word;
  assign w_drv = {w_cw[RO_B], w_cw[IO_B], w_cw[AO_B], w_cw[EO_B], w_cw[CO_B]};

  sap_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (r_a),
    .b      (r_b),
    .su     (w_cw[SU_B]),
    .result (w_alu),
    .carry  (w_alu_c),
    .zero   (w_alu_z)
  );

  // Priority bus mux: RO > IO > AO > EO > CO, idle bus reads zero.
  always_comb begin
    w_bus = {DATA_W{1'b0}};
    if (w_cw[RO_B])      w_bus = r_ram[r_mar];
    else if (w_cw[IO_B]) w_bus = {{(DATA_W-4){1'b0}}, r_ir[3:0]};
    else if (w_cw[AO_B]) w_bus = r_a;
    else if (w_cw[EO_B]) w_bus = w_alu;
    else if (w_cw[CO_B]) w_bus = {{(DATA_W-ADDR_W){1'b0}}, r_pc};
    else                 w_bus = {DATA_W{1'b0}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a        <= {DATA_W{1'b0}};
      r_b        <= {DATA_W{1'b0}};
      r_ir       <= {DATA_W{1'b0}};
      r_out      <= {DATA_W{1'b0}};
      r_mar      <= {ADDR_W{1'b0}};
      r_pc       <= {ADDR_W{1'b0}};
      r_carry    <= 1'b0;
      r_zero     <= 1'b0;
      r_halted   <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      if (w_cw[MI_B]) r_mar <= w_bus[ADDR_W-1:0];
      if (w_cw[II_B]) r_ir  <= w_bus;
      if (w_cw[AI_B]) r_a   <= w_bus;
      if (w_cw[BI_B]) r_b   <= w_bus;
      if (w_cw[OI_B]) r_out <= w_bus;
      if (w_cw[FI_B]) begin
        r_carry <= w_alu_c;
        r_zero  <= w_alu_z;
      end
      if (w_cw[J_B])       r_pc <= w_bus[ADDR_W-1:0];
      else if (w_cw[CE_B]) r_pc <= r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
      if (w_cw[HLT_B])         r_halted   <= 1'b1;
      if (multi_driver(w_drv)) r_conflict <= 1'b1;
    end
  end

  // RAM is not reset; programming port overrides an RI store in the same cycle.
  always_ff @(posedge clk) begin
    if (prog_we)                 r_ram[prog_addr] <= prog_data;
    else if (w_cw[RI_B] && !rst) r_ram[r_mar]     <= w_bus;
  end

  assign instruction  = r_ir[DATA_W-1 -: 4];
  assign carry_flag   = r_carry;
  assign zero_flag    = r_zero;
  assign out_data     = r_out;
  assign halted       = r_halted;
  assign bus_conflict = r_conflict;
  assign pc           = r_pc;
  assign bus          = w_bus;

endmodule

// File: tb/tb_sap_datapath.sv
// Scoreboard bench for sap_datapath: directed program fragments plus random
// control words, checked against a plain-arithmetic machine model.
module tb_sap_datapath;

  localparam logic [15:0] HLT = 16'h8000, MI = 16'h4000, RI = 16'h2000, RO = 16'h1000;
  localparam logic [15:0] IO  = 16'h0800, II = 16'h0400, AI = 16'h0200, AO = 16'h0100;
  localparam logic [15:0] EO  = 16'h0080, SU = 16'h0040, BI = 16'h0020, OI = 16'h0010;
  localparam logic [15:0] CE  = 16'h0008, CO = 16'h0004, J  = 16'h0002, FI = 16'h0001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] ctrl_word = 16'h0000;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = 4'h0;
  logic [7:0]  prog_data = 8'h00;
  logic [3:0]  instruction;
  logic        carry_flag, zero_flag, halted, bus_conflict;
  logic [7:0]  out_data, bus;
  logic [3:0]  pc;

  always #5 clk = ~clk;

  sap_datapath #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .ctrl_word(ctrl_word),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .instruction(instruction), .carry_flag(carry_flag), .zero_flag(zero_flag),
    .out_data(out_data), .halted(halted), .bus_conflict(bus_conflict),
    .pc(pc), .bus(bus)
  );

  typedef struct packed {
    logic [3:0] instr;
    logic       c;
    logic       z;
    logic [7:0] outd;
    logic       halt;
    logic       conf;
    logic [3:0] pc;
    logic [7:0] bus;
  } exp_t;

  exp_t       state_q[$];
  logic [7:0] bus_q[$];
  int n_err = 0;
  int n_chk = 0;

  // Reference machine state.
  logic [7:0] m_a, m_b, m_ir, m_out;
  logic [3:0] m_mar, m_pc;
  logic       m_c, m_z, m_halt, m_conf;
  logic [7:0] m_ram [16];

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endfunction

  function automatic int alu_int(input logic su);
    int ia, ib;
    ia = int'(m_a);
    ib = int'(m_b);
    return su ? (ia - ib) : (ia + ib);
  endfunction

  function automatic logic [7:0] m_bus_of(input logic [15:0] cw);
    int s;
    if (m_halt) return 8'h00;
    s = alu_int((cw & SU) != 16'h0);
    if ((cw & RO) != 16'h0) return m_ram[m_mar];
    if ((cw & IO) != 16'h0) return {4'h0, m_ir[3:0]};
    if ((cw & AO) != 16'h0) return m_a;
    if ((cw & EO) != 16'h0) return s[7:0];
    if ((cw & CO) != 16'h0) return {4'h0, m_pc};
    return 8'h00;
  endfunction

  task automatic model_step(input logic [15:0] cw, input logic pwe, input logic [3:0] pa,
                            input logic [7:0] pd, output logic [7:0] pre_bus, output exp_t post);
    logic [15:0] e;
    logic [7:0]  b;
    logic [3:0]  old_mar;
    int          s, ndrv;
    logic        su, cy;
    e       = m_halt ? 16'h0 : cw;
    b       = m_bus_of(cw);
    pre_bus = b;
    su      = (e & SU) != 16'h0;
    s       = alu_int(su);
    cy      = su ? (int'(m_a) >= int'(m_b)) : (s > 255);
    ndrv    = $countones(e & (RO | IO | AO | EO | CO));
    old_mar = m_mar;
    if ((e & MI) != 16'h0) m_mar = b[3:0];
    if ((e & II) != 16'h0) m_ir = b;
    if ((e & AI) != 16'h0) m_a = b;
    if ((e & BI) != 16'h0) m_b = b;
    if ((e & OI) != 16'h0) m_out = b;
    if ((e & FI) != 16'h0) begin
      m_c = cy;
      m_z = (s[7:0] == 8'h00);
    end
    if ((e & J) != 16'h0)       m_pc = b[3:0];
    else if ((e & CE) != 16'h0) m_pc = m_pc + 4'd1;
    if (pwe)                        m_ram[pa] = pd;
    else if ((e & RI) != 16'h0)     m_ram[old_mar] = b;
    if ((e & HLT) != 16'h0) m_halt = 1'b1;
    if (ndrv > 1)           m_conf = 1'b1;
    post = '{instr: m_ir[7:4], c: m_c, z: m_z, outd: m_out, halt: m_halt,
             conf: m_conf, pc: m_pc, bus: m_bus_of(cw)};
  endtask

  task automatic step(input logic [15:0] cw, input logic pwe = 1'b0,
                      input logic [3:0] pa = 4'h0, input logic [7:0] pd = 8'h00);
    logic [7:0] pb;
    exp_t       post;
    @(negedge clk);
    ctrl_word = cw;
    prog_we   = pwe;
    prog_addr = pa;
    prog_data = pd;
    model_step(cw, pwe, pa, pd, pb, post);
    bus_q.push_back(pb);
    state_q.push_back(post);
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    ctrl_word = 16'h0;
    prog_we   = 1'b0;
    rst       = 1'b1;
    #1;
    chk("rst_instruction", 32'(instruction), 32'h0);
    chk("rst_carry", 32'(carry_flag), 32'h0);
    chk("rst_zero", 32'(zero_flag), 32'h0);
    chk("rst_out", 32'(out_data), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_conflict", 32'(bus_conflict), 32'h0);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_bus", 32'(bus), 32'h0);
    m_a = 8'h0; m_b = 8'h0; m_ir = 8'h0; m_out = 8'h0;
    m_mar = 4'h0; m_pc = 4'h0;
    m_c = 1'b0; m_z = 1'b0; m_halt = 1'b0; m_conf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: bus value for the word currently applied, before the edge.
  always @(negedge clk) begin
    logic [7:0] e;
    #1;
    if (bus_q.size() > 0) begin
      e = bus_q.pop_front();
      chk("bus_pre", 32'(bus), 32'(e));
    end
  end

  // Monitor: architectural outputs after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (state_q.size() > 0) begin
      e = state_q.pop_front();
      chk("instruction", 32'(instruction), 32'(e.instr));
      chk("carry", 32'(carry_flag), 32'(e.c));
      chk("zero", 32'(zero_flag), 32'(e.z));
      chk("out_data", 32'(out_data), 32'(e.outd));
      chk("halted", 32'(halted), 32'(e.halt));
      chk("bus_conflict", 32'(bus_conflict), 32'(e.conf));
      chk("pc", 32'(pc), 32'(e.pc));
      chk("bus_post", 32'(bus), 32'(e.bus));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [15:0] rcw;
    do_reset();
    for (int i = 0; i < 16; i++) step(16'h0, 1'b1, 4'(i), 8'($urandom_range(0, 255)));

    // Fetch.
    step(16'h0, 1'b1, 4'h0, 8'h1E);
    step(MI | CO);
    step(RO | II | CE);
    step(IO | MI);
    // ADD 1C + 28, then F0 + 10 (same-cycle prog write: RO sees old data).
    step(16'h0, 1'b1, 4'hE, 8'h1C);
    step(RO | AI, 1'b1, 4'hE, 8'h28);
    step(RO | BI);
    step(EO | AI | FI);
    step(AO | OI);
    step(16'h0, 1'b1, 4'hE, 8'hF0);
    step(RO | AI, 1'b1, 4'hE, 8'h10);
    step(RO | BI);
    step(EO | AI | FI);
    step(AO | OI);
    // SUB 05 - 07.
    step(16'h0, 1'b1, 4'hE, 8'h05);
    step(RO | AI, 1'b1, 4'hE, 8'h07);
    step(RO | BI);
    step(EO | AI | SU | FI);
    step(AO | OI);
    // PC wrap, then J beats CE.
    step(16'h0, 1'b1, 4'hE, 8'h63);
    step(RO | II);
    for (int i = 0; i < 16 && m_pc != 4'hF; i++) step(CE);
    step(CE);
    step(IO | J | CE);

    for (int i = 0; i < 400; i++) begin
      rcw = 16'($urandom) & ~HLT;
      step(rcw, ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    end
    do_reset();
    step(RO | OI);
    for (int i = 0; i < 200; i++) begin
      rcw = 16'($urandom) & ~HLT;
      step(rcw, ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    end

    // Conflict and halt.
    do_reset();
    step(16'h0, 1'b1, 4'h0, 8'h11);
    step(RO | AI, 1'b1, 4'h0, 8'h22);
    step(AO | RO);
    step(HLT | OI | AO);
    step(AI | RO);
    step(AI, 1'b1, 4'h0, 8'h5A);
    step(AO | OI | CE);
    do_reset();
    step(RO | OI);
    step(AO | OI);

    repeat (3) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sap_datapath.md
# sap_datapath

Execution datapath for the 8-bit SAP-style computer: consumes the 16-bit control word from the microcode sequencer and applies it to the bus, registers, RAM, ALU, program counter and flags. It returns the 4-bit opcode and the carry/zero flags to the sequencer. It is the receiving end of the control-word interface. The sequencer drives the word, and this block executes it.

## Interface
- DATA_W, 8: bus/register width; the opcode is IR[DATA_W-1 -: 4].
- ADDR_W, 4: RAM address, MAR and PC width; RAM depth is 2**ADDR_W.
- clk  in  1  the single clock; every register updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- ctrl_word  in  16  control word: bit15 HLT, 14 MI, 13 RI, 12 RO, 11 IO, 10 II, 9 AI, 8 AO, 7 EO, 6 SU, 5 BI, 4 OI, 3 CE, 2 CO, 1 J, 0 FI.
- prog_we  in  1  RAM programming write strobe.
- prog_addr  in  ADDR_W  programming address.
- prog_data  in  DATA_W  programming data.
- instruction  out  4  IR[7:4], driven combinationally from IR.
- carry_flag, zero_flag  out  1  each  flag register outputs.
- out_data  out  DATA_W  output register.
- halted  out  1  sticky halt indication.
- bus_conflict  out  1  sticky flag set when more than one bus driver is asserted.
- pc  out  ADDR_W  program counter (debug).
- bus  out  DATA_W  current bus value (debug).

## Operation
- **Bus drivers.** RO drives RAM[MAR]. IO drives {0, IR[3:0]}. AO drives A. EO drives the ALU result. CO drives {0, PC}.
  - With no driver asserted, the bus is 0.
  - With several drivers asserted, priority is RO > IO > AO > EO > CO, and bus_conflict is set. bus_conflict stays set until reset.
- **Register loads (posedge, from the bus).** MI loads MAR ← bus[ADDR_W-1:0]. II loads IR. AI loads A. BI loads B. OI loads out_data. RI writes RAM[MAR] ← bus.
- **ALU.** Result is 9 bits.
  - SU=0: A + B.
  - SU=1: A + ~B + 1.
  - Carry is bit 8, so during SU carry=1 means A ≥ B (no borrow).
  - Zero means result[7:0] == 0.
  - FI latches both carry and zero. Flags are unchanged otherwise.
- **Program counter.**
  - J loads PC ← bus[ADDR_W-1:0].
  - CE increments PC modulo 2**ADDR_W, so 15 wraps to 0.
  - If J and CE are asserted together, J wins.
- **Read-before-write.** Within a cycle, every destination samples the pre-edge bus. AI|EO therefore loads the sum computed from the old A.
- **Halt.**
  - A word containing HLT still executes its other bits that edge, and halted becomes 1.
  - While halted=1, ctrl_word is ignored entirely.
  - Only rst clears halted.
- **RAM programming.** prog_we writes RAM[prog_addr] on any edge, whether halted or not. If prog_we and RI are asserted the same cycle, prog_we wins and the RI write is dropped.
- **Reset.**
  - On reset: A, B, IR, MAR, PC, out_data, carry_flag, zero_flag, halted and bus_conflict are all 0, so instruction=0 and bus=0.
  - RAM contents are not reset.
  - Reset asserted mid-instruction clears state immediately; the cycle's writes are lost.

## Timing
- ctrl_word must be stable across posedge clk. At the top level the sequencer is clocked on ~clk, so each word is valid half a cycle before it is consumed.
- A register load is visible one cycle after the edge at which its control word is sampled.
- instruction, flags and bus have zero additional latency after their source registers.
- RAM is an asynchronous read with a synchronous write. A read issued on the same edge as a write to the same address returns the old data that cycle.
- No handshake: one control word executes per cycle while not halted.

## Structure
- Shared package sap_pkg holds:
  - control-bit index localparams (HLT_B=15 … FI_B=0);
  - the opcode constants (NOP 0, LDA 1, ADD 2, SUB 3, STA 4, LDI 5, JMP 6, JC 7, JZ 8, OUT 14, HLT 15).
- The sequencer includes the same package.
- Sub-module sap_alu is combinational: inputs a, b, su; outputs result[7:0], carry, zero.
- RAM is an inferred array in sap_datapath.

## Test plan
- **Reset.** Assert rst mid-run → every output 0; RAM value preloaded via prog is preserved.
- **Fetch.** Preload RAM[0]=8'h1E. Apply MI|CO, then RO|II|CE → IR=8'h1E, instruction=1, pc=1. With IO|MI next → MAR=14.
- **ADD.** A=8'h1C, RAM[14]=8'h28. Apply RO|BI, then EO|AI|FI → A=8'h44, carry=0, zero=0.
  - Then A=8'hF0, B=8'h10 with EO|AI|FI → A=0, carry=1, zero=1.
- **SUB.** A=8'h05, B=8'h07 with EO|AI|SU|FI → A=8'hFE, carry=0, zero=0.
- **PC.** At pc=15, CE → pc=0. LDI-style IO|J with IR=8'h63 and CE simultaneously → pc=3.
- **Halt and conflict.**
  - AO|RO with A=8'h11, RAM[MAR]=8'h22 → bus=8'h22, bus_conflict=1.
  - HLT|OI → out_data loaded and halted=1. Subsequent AI words leave A unchanged; prog_we still writes RAM.
